// File: rtl/fb_pkg.sv
// Shared frame-buffer types and screen geometry, also used by the sprite
// controller and VGA timing.
package fb_pkg;

    localparam int SCREEN_W = 256;
    localparam int SCREEN_H = 256;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        SWAP,
        COPY
    } fb_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic in_bounds(input logic [7:0] x, input logic [7:0] y,
                                       input int w, input int h);
        return (int'(x) < w) && (int'(y) < h);
    endfunction

    function automatic logic [15:0] pixel_addr(input logic [7:0] x, input logic [7:0] y,
                                               input int w);
        return 16'(int'(y) * w + int'(x));
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM with one write port and one
// registered, enabled read port. Contents are never reset.
module fb_bank
    import fb_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  rgb_t              wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output rgb_t              rdata_o
);

    rgb_t mem_q [DEPTH];
    rgb_t rdata_q;

    // Read data holds until the next enabled read, which the copy pipeline relies on.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_swap.sv
// Double-buffered 24-bit frame store: pixel writes go to the back bank, a display
// request swaps banks on the next vblank rising edge and optionally copies front->back.
module frame_buffer_swap
    import fb_pkg::*;
#(
    parameter int FB_W         = SCREEN_W,
    parameter int FB_H         = SCREEN_H,
    parameter int COPY_ON_SWAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  x_i,
    input  logic [7:0]  y_i,
    input  logic [7:0]  r_i,
    input  logic [7:0]  g_i,
    input  logic [7:0]  b_i,
    input  logic        write_i,
    input  logic        display_i,
    output logic        busy_o,
    input  logic        vblank_i,
    input  logic        rd_en_i,
    input  logic [7:0]  rd_x_i,
    input  logic [7:0]  rd_y_i,
    output logic [23:0] rd_rgb_o,
    output logic        rd_valid_o,
    output logic        wr_drop_o
);

    localparam int DEPTH  = FB_W * FB_H;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fb_state_t         state_q, state_d;
    logic              front_sel_q, front_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cp_pend_q, cp_pend_d;
    logic [ADDR_W-1:0] cp_addr_q, cp_addr_d;
    logic              wr_drop_q, wr_drop_d;
    logic              vblank_q;
    logic              rd_valid_q, rd_oob_q, rd_bank_q;

    logic              wr_ok, rd_ok;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    rgb_t              wr_rgb;

    logic              back_we, front_re;
    logic [ADDR_W-1:0] back_waddr, front_raddr;
    rgb_t              back_wdata, front_rdata, scan_rdata;
    rgb_t              rdata0, rdata1;

    assign wr_ok   = in_bounds(x_i, y_i, FB_W, FB_H);
    assign rd_ok   = in_bounds(rd_x_i, rd_y_i, FB_W, FB_H);
    assign wr_addr = ADDR_W'(pixel_addr(x_i, y_i, FB_W));
    assign rd_addr = ADDR_W'(pixel_addr(rd_x_i, rd_y_i, FB_W));
    assign wr_rgb  = {r_i, g_i, b_i};

    assign front_rdata = front_sel_q ? rdata1 : rdata0;
    assign scan_rdata  = rd_bank_q ? rdata1 : rdata0;

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        cnt_d       = cnt_q;
        cp_pend_d   = 1'b0;
        cp_addr_d   = cp_addr_q;
        wr_drop_d   = wr_drop_q;
        back_we     = 1'b0;
        back_waddr  = wr_addr;
        back_wdata  = wr_rgb;
        front_re    = rd_en_i && rd_ok;
        front_raddr = rd_addr;

        if (write_i && (state_q != IDLE || !wr_ok)) begin
            wr_drop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                back_we = write_i && wr_ok;
                if (display_i) begin
                    state_d = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vblank_i && !vblank_q) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                front_sel_d = ~front_sel_q;
                cnt_d       = '0;
                state_d     = (COPY_ON_SWAP != 0) ? COPY : IDLE;
            end
            COPY: begin
                // Scanout owns the front read port whenever it asks; the copy just slips a cycle.
                if (!rd_en_i && cnt_q != CNT_END) begin
                    front_re    = 1'b1;
                    front_raddr = cnt_q[ADDR_W-1:0];
                    cnt_d       = cnt_q + CNT_W'(1);
                    cp_pend_d   = 1'b1;
                    cp_addr_d   = cnt_q[ADDR_W-1:0];
                end
                if (cp_pend_q) begin
                    back_we    = 1'b1;
                    back_waddr = cp_addr_q;
                    back_wdata = front_rdata;
                    if (cp_addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            cnt_q       <= '0;
            cp_pend_q   <= 1'b0;
            cp_addr_q   <= '0;
            wr_drop_q   <= 1'b0;
            vblank_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_oob_q    <= 1'b0;
            rd_bank_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            cnt_q       <= cnt_d;
            cp_pend_q   <= cp_pend_d;
            cp_addr_q   <= cp_addr_d;
            wr_drop_q   <= wr_drop_d;
            vblank_q    <= vblank_i;
            rd_valid_q  <= rd_en_i;
            rd_oob_q    <= !rd_ok;
            rd_bank_q   <= front_sel_q;
        end
    end

    // Bank 0 is front when front_sel is 0; a copy write in flight is dropped by reset.
    fb_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
        .clk     (clk),
        .we_i    (back_we && front_sel_q && !rst),
        .waddr_i (back_waddr),
        .wdata_i (back_wdata),
        .re_i    (front_re && !front_sel_q),
        .raddr_i (front_raddr),
        .rdata_o (rdata0)
    );

    fb_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
        .clk     (clk),
        .we_i    (back_we && !front_sel_q && !rst),
        .waddr_i (back_waddr),
        .wdata_i (back_wdata),
        .re_i    (front_re && front_sel_q),
        .raddr_i (front_raddr),
        .rdata_o (rdata1)
    );

    assign busy_o     = (state_q != IDLE);
    assign rd_valid_o = rd_valid_q;
    assign rd_rgb_o   = (rd_valid_q && !rd_oob_q) ? scan_rdata : 24'h000000;
    assign wr_drop_o  = wr_drop_q;

endmodule

// File: tb/tb_frame_buffer_swap.sv
// Directed bench for frame_buffer_swap on a 4x4 screen with copy-on-swap enabled:
// swap/vblank handling, copy length and stalls, dropped writes, reset mid-copy.
module tb_frame_buffer_swap;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  x, y, r, g, b;
    logic        write, display, vblank;
    logic        rd_en;
    logic [7:0]  rd_x, rd_y;
    logic        busy, rd_valid, wr_drop;
    logic [23:0] rd_rgb;

    int compared   = 0;
    int mismatched = 0;
    int n;

    frame_buffer_swap #(.FB_W(4), .FB_H(4), .COPY_ON_SWAP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .x_i        (x),
        .y_i        (y),
        .r_i        (r),
        .g_i        (g),
        .b_i        (b),
        .write_i    (write),
        .display_i  (display),
        .busy_o     (busy),
        .vblank_i   (vblank),
        .rd_en_i    (rd_en),
        .rd_x_i     (rd_x),
        .rd_y_i     (rd_y),
        .rd_rgb_o   (rd_rgb),
        .rd_valid_o (rd_valid),
        .wr_drop_o  (wr_drop)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic writePix(input logic [7:0] px, input logic [7:0] py, input logic [23:0] c);
        x = px; y = py; {r, g, b} = c; write = 1'b1;
        applyStimulus();
        write = 1'b0;
    endtask

    task automatic readPix(input logic [7:0] px, input logic [7:0] py,
                           input logic [23:0] exp, input string tag);
        rd_x = px; rd_y = py; rd_en = 1'b1;
        applyStimulus();
        rd_en = 1'b0;
        checkOutput({tag, "_valid"}, 24'(rd_valid), 24'd1);
        checkOutput(tag, rd_rgb, exp);
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            applyStimulus();
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; x = '0; y = '0; r = '0; g = '0; b = '0;
        write = 1'b0; display = 1'b0; vblank = 1'b0;
        rd_en = 1'b0; rd_x = '0; rd_y = '0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_busy", 24'(busy), 24'd0);
        checkOutput("reset_valid", 24'(rd_valid), 24'd0);
        checkOutput("reset_rgb", rd_rgb, 24'h000000);
        checkOutput("reset_drop", 24'(wr_drop), 24'd0);
        rst = 1'b0;

        // Fill the back bank (bank1), present it, and let the copy run.
        writePix(3, 2, 24'hFF0000);
        writePix(3, 3, 24'h123456);
        writePix(0, 0, 24'h0000FF);
        writePix(0, 1, 24'h010101);
        writePix(1, 1, 24'hC0C0C0);
        checkOutput("t1_no_drop", 24'(wr_drop), 24'd0);
        display = 1'b1;
        applyStimulus();
        display = 1'b0;
        checkOutput("t1_busy_wait", 24'(busy), 24'd1);
        vblank = 1'b1;
        applyStimulus();
        vblank = 1'b0;
        checkOutput("t1_busy_swap", 24'(busy), 24'd1);
        applyStimulus();
        waitIdle(n);
        checkOutput("t3_copy_cycles", 24'(n), 24'd17);
        readPix(3, 2, 24'hFF0000, "t1_read_32");

        // Out-of-range write, back-bank overwrite, consecutive same-address writes.
        writePix(4, 0, 24'h777777);
        checkOutput("t4_drop_oob", 24'(wr_drop), 24'd1);
        writePix(1, 1, 24'h00FF00);
        writePix(2, 0, 24'h111111);
        writePix(2, 0, 24'h222222);

        // Display while vblank is already high must wait for the next rising edge.
        vblank = 1'b1;
        applyStimulus();
        display = 1'b1;
        applyStimulus();
        display = 1'b0;
        writePix(0, 0, 24'hAAAAAA);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t2_busy_hold", 24'(busy), 24'd1);
        end
        readPix(1, 1, 24'hC0C0C0, "t2_front_unchanged");
        checkOutput("t2_busy_after_read", 24'(busy), 24'd1);
        vblank = 1'b0;
        applyStimulus();
        vblank = 1'b1;
        applyStimulus();
        vblank = 1'b0;
        checkOutput("t2_busy_swap", 24'(busy), 24'd1);
        applyStimulus();

        // Scanout steals five cycles from the copy; every read returns front data.
        rd_x = 1; rd_y = 1; rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("t5_steal_valid", 24'(rd_valid), 24'd1);
            checkOutput("t5_steal_rgb", rd_rgb, 24'h00FF00);
        end
        rd_en = 1'b0;
        waitIdle(n);
        checkOutput("t5_copy_remaining", 24'(n), 24'd17);

        readPix(0, 0, 24'h0000FF, "t4_busy_write_dropped");
        readPix(0, 1, 24'h010101, "t4_oob_no_alias");
        readPix(2, 0, 24'h222222, "last_write_wins");
        readPix(3, 3, 24'h123456, "t3_copied_33");
        readPix(1, 1, 24'h00FF00, "new_front_11");
        readPix(0, 4, 24'h000000, "oob_read_zero");

        // Write and display together, then reset in the middle of the copy.
        x = 1; y = 1; {r, g, b} = 24'hABCDEF; write = 1'b1; display = 1'b1;
        applyStimulus();
        write = 1'b0; display = 1'b0;
        checkOutput("t6_busy", 24'(busy), 24'd1);
        vblank = 1'b1;
        applyStimulus();
        vblank = 1'b0;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("t6_in_copy", 24'(busy), 24'd1);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("t6_busy_after_rst", 24'(busy), 24'd0);
        checkOutput("t6_drop_cleared", 24'(wr_drop), 24'd0);
        readPix(1, 1, 24'h00FF00, "t6_front_bank0");

        writePix(3, 0, 24'h5A5A5A);
        display = 1'b1;
        applyStimulus();
        display = 1'b0;
        vblank = 1'b1;
        applyStimulus();
        vblank = 1'b0;
        applyStimulus();
        waitIdle(n);
        checkOutput("t6_copy_cycles", 24'(n), 24'd17);
        readPix(3, 0, 24'h5A5A5A, "t6_new_write");
        readPix(1, 1, 24'hABCDEF, "t6_same_cycle_write");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
